sram_alu_datapath: RTL and testbench
====================================

Name: sram_alu_datapath

Overview:
- Execution datapath that responds to the main controller's control outputs: WR, ADDR, Data, DIR_SRAM, DIR_EXE and OP_ALU.
- Contains an 8x4 register SRAM, two operand latches, a result register and an add/sub ALU.
- Returns the OV flag to the controller and exposes read data on DOUT.
- Sits between the main controller and the chip I/O: the controller sequences it, and this block does the storage and arithmetic.

Parameters:
- DATA_W, 4, SRAM word and ALU width
- ADDR_W, 3, SRAM address width
- DEPTH, 2**ADDR_W, number of SRAM words

Ports:
- CLK  input  1  system clock, rising edge
- RST  input  1  asynchronous, active-low reset
- WR  input  1  1 = write SRAM[ADDR] this cycle; 0 = read
- ADDR  input  ADDR_W  SRAM address
- Data  input  DATA_W  immediate write data
- DIR_SRAM  input  1  write-data select: 0 = Data, 1 = result register R
- DIR_EXE  input  2  execute step: 00 idle, 01 latch operand A, 10 latch operand B, 11 execute
- OP_ALU  input  1  0 = A+B, 1 = A-B
- OV  output  1  registered signed overflow of the last execute
- DOUT  output  DATA_W  registered SRAM read data
- RES  output  DATA_W  result register R

Behaviour:
- Reset (RST=0, asynchronous): all SRAM words, A, B, R, OV and DOUT clear to 0. The clock is ignored while RST=0.
- Asserting reset mid-sequence aborts the sequence. Nothing partial survives; all state is 0 on release.
- Read port: combinational rd = SRAM[ADDR], used by DOUT and by the operand latches.
- Write: when WR=1, at the clock edge SRAM[ADDR] <= (DIR_SRAM ? R : Data).
- DOUT: when WR=0, DOUT <= rd at the edge (1-cycle latency). When WR=1, DOUT holds.
- DIR_EXE=01: A <= rd. DIR_EXE=10: B <= rd. Both capture the pre-write value, even if WR=1 to the same ADDR in the same cycle (read-before-write).
- DIR_EXE=11: R <= A op B, modulo 2**DATA_W, and OV <= overflow.
- Overflow is signed two's complement:
  - add: A[3]==B[3] and R[3]!=A[3]
  - sub: A[3]!=B[3] and R[3]!=A[3]
- OV holds until the next execute or reset.
- DIR_EXE=00: A, B, R and OV hold.
- Execute and write-back in the same cycle (DIR_EXE=11, WR=1, DIR_SRAM=1): the pre-update R is written. Write-back therefore needs one cycle after execute.
- Any ADDR value is legal; no out-of-range case exists at DEPTH = 2**ADDR_W.
- Controller sequences supported:
  - read: 1 cycle
  - write immediate: 1 cycle
  - ALU op: latch A, latch B, execute, write-back = 4 cycles, with R valid on RES from the cycle after execute.

Optional Feature:
- Macro: SRAM_ALU_DATAPATH_SAT_EN.
- Defined: on overflow, R saturates to 0111 (positive overflow) or 1000 (negative overflow). OV is still set.
- Undefined: R wraps modulo 2**DATA_W.

Decomposition:
- Package datapath_pkg holds:
  - DIR_EXE encodings: EXE_IDLE=2'b00, EXE_LDA=2'b01, EXE_LDB=2'b10, EXE_RUN=2'b11
  - OP_ALU encodings: ALU_ADD=0, ALU_SUB=1
  - DIR_SRAM encodings: SRC_IMM=0, SRC_ALU=1
  - DATA_W and ADDR_W defaults
- One sub-module, alu_addsub: combinational A, B, op -> sum and ov, with saturation under the macro. Registers stay in the parent.

Test Plan:
- Reset: hold RST=0 after random prior writes -> DOUT, RES, OV = 0, and reading every address returns 0. Release RST, then read 010 -> DOUT=0000 one cycle later.
- Write/read: WR=1, ADDR=010, Data=1111, DIR_SRAM=0 -> next cycle WR=0, ADDR=010 -> DOUT=1111 one cycle after.
- Add and write-back: SRAM[001]=0011, SRAM[011]=0100 -> LDA 001, LDB 011, RUN with OP_ALU=0 -> RES=0111, OV=0. Then WR=1, ADDR=101, DIR_SRAM=1 -> reading 101 gives 0111.
- Overflow: A=0111, B=0001 add -> RES=1000 (or 0111 with SAT_EN), OV=1. A=1000, B=0001 sub -> RES=0111 (or 1000 with SAT_EN), OV=1. A=0011, B=0101 sub -> RES=1110, OV=0, clearing the prior OV.
- Same-cycle hazards:
  - LDA on 011 with WR=1 writing 1010 to 011 -> A = old value.
  - RUN with WR=1, DIR_SRAM=1 -> the old R is written.
- Reset mid-operation: assert RST between LDB and RUN -> RES=0 and OV=0. After release, RUN gives RES=0000 because A=B=0.

Source files
------------

// File: rtl/sram_alu_datapath_pkg.sv
// sram_alu_datapath_pkg: shared encodings and default widths for the SRAM/ALU datapath
// Contents:
//   exe_e      - DIR_EXE execute-step encodings
//   alu_op_e   - OP_ALU operation encodings
//   src_e      - DIR_SRAM write-data source encodings
//   DEF_DATA_W - default data width, DEF_ADDR_W - default address width
package datapath_pkg;
    localparam int DEF_DATA_W = 4;
    localparam int DEF_ADDR_W = 3;
    typedef enum logic [1:0] {
        EXE_IDLE = 2'b00,
        EXE_LDA  = 2'b01,
        EXE_LDB  = 2'b10,
        EXE_RUN  = 2'b11
    } exe_e;
    typedef enum logic {
        ALU_ADD = 1'b0,
        ALU_SUB = 1'b1
    } alu_op_e;
    typedef enum logic {
        SRC_IMM = 1'b0,
        SRC_ALU = 1'b1
    } src_e;
endpackage

// File: rtl/sram_alu_datapath_alu_addsub.sv
// alu_addsub: combinational add/sub with signed overflow flag (saturating when SRAM_ALU_DATAPATH_SAT_EN is defined)
// Ports:
//   a_i, b_i - operands
//   op_i     - 0 add, 1 subtract (a_i - b_i)
//   res_o    - result, wrapped or saturated
//   ov_o     - signed two's-complement overflow
// Macro: SRAM_ALU_DATAPATH_SAT_EN selects saturation on overflow.
module alu_addsub
    import datapath_pkg::*;
#(
    parameter int W = DEF_DATA_W
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         op_i,
    output logic [W-1:0] res_o,
    output logic         ov_o
);
    logic [W-1:0] sum;
    always_comb begin
        sum  = (op_i == ALU_SUB) ? a_i - b_i : a_i + b_i;
        // overflow iff operand signs make the true result representable in neither direction
        ov_o = ((op_i == ALU_SUB) ? (a_i[W-1] != b_i[W-1]) : (a_i[W-1] == b_i[W-1]))
               && (sum[W-1] != a_i[W-1]);
`ifdef SRAM_ALU_DATAPATH_SAT_EN
        // sign of a_i tells the overflow direction: positive a overflows upward
        res_o = ov_o ? (a_i[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}}) : sum;
`else
        res_o = sum;
`endif
    end
endmodule

// File: rtl/sram_alu_datapath.sv
// sram_alu_datapath: controller-driven 8x4 SRAM with operand latches, add/sub ALU and result register
// Ports:
//   CLK      - clock, rising edge
//   RST      - asynchronous active-low reset, clears all state
//   WR       - 1 writes SRAM[ADDR], 0 reads into DOUT
//   ADDR     - SRAM address
//   Data     - immediate write data
//   DIR_SRAM - write source: 0 Data, 1 result register
//   DIR_EXE  - 00 idle, 01 latch A, 10 latch B, 11 execute
//   OP_ALU   - 0 add, 1 subtract
//   OV       - overflow of the last execute
//   DOUT     - registered read data
//   RES      - result register
// Macro: SRAM_ALU_DATAPATH_SAT_EN enables saturating results in the ALU.
module sram_alu_datapath
    import datapath_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              WR,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] Data,
    input  logic              DIR_SRAM,
    input  logic [1:0]        DIR_EXE,
    input  logic              OP_ALU,
    output logic              OV,
    output logic [DATA_W-1:0] DOUT,
    output logic [DATA_W-1:0] RES
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, r_q, r_d, dout_q, dout_d;
    logic              ov_q, ov_d;
    logic [DATA_W-1:0] rd, wdata, alu_res;
    logic              alu_ov;

    alu_addsub #(.W(DATA_W)) u_alu (
        .a_i   (a_q),
        .b_i   (b_q),
        .op_i  (OP_ALU),
        .res_o (alu_res),
        .ov_o  (alu_ov)
    );

    // all next-state values come from pre-edge state, giving read-before-write
    // for the latches and old-R write-back when execute and write coincide
    always_comb begin
        rd     = mem_q[ADDR];
        wdata  = (DIR_SRAM == SRC_ALU) ? r_q : Data;
        a_d    = (DIR_EXE == EXE_LDA) ? rd : a_q;
        b_d    = (DIR_EXE == EXE_LDB) ? rd : b_q;
        r_d    = (DIR_EXE == EXE_RUN) ? alu_res : r_q;
        ov_d   = (DIR_EXE == EXE_RUN) ? alu_ov : ov_q;
        dout_d = WR ? dout_q : rd;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            a_q    <= '0;
            b_q    <= '0;
            r_q    <= '0;
            ov_q   <= 1'b0;
            dout_q <= '0;
        end else begin
            if (WR) mem_q[ADDR] <= wdata;
            a_q    <= a_d;
            b_q    <= b_d;
            r_q    <= r_d;
            ov_q   <= ov_d;
            dout_q <= dout_d;
        end
    end

    assign OV   = ov_q;
    assign DOUT = dout_q;
    assign RES  = r_q;
endmodule

// File: tb/tb_sram_alu_datapath.sv
// tb_sram_alu_datapath: directed and random stimulus checked against a signed-arithmetic reference model
module tb_sram_alu_datapath;
    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       WR = 1'b0;
    logic [2:0] ADDR = '0;
    logic [3:0] Data = '0;
    logic       DIR_SRAM = 1'b0;
    logic [1:0] DIR_EXE = '0;
    logic       OP_ALU = 1'b0;
    logic       OV;
    logic [3:0] DOUT, RES;

`ifdef SRAM_ALU_DATAPATH_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    sram_alu_datapath dut (
        .CLK(CLK), .RST(RST), .WR(WR), .ADDR(ADDR), .Data(Data),
        .DIR_SRAM(DIR_SRAM), .DIR_EXE(DIR_EXE), .OP_ALU(OP_ALU),
        .OV(OV), .DOUT(DOUT), .RES(RES)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_fail = 0;
    int m_mem [8];
    int m_a, m_b, m_r, m_ov, m_dout;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        foreach (m_mem[i]) m_mem[i] = 0;
        m_a = 0; m_b = 0; m_r = 0; m_ov = 0; m_dout = 0;
    endtask

    function automatic int sgn(input int v);
        return v >= 8 ? v - 16 : v;
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, ".dout"}, int'(DOUT), m_dout);
        check({tag, ".res"}, int'(RES), m_r);
        check({tag, ".ov"}, int'(OV), m_ov);
    endtask

    // one controller cycle: drive at negedge, model the edge, check at next negedge
    task automatic cycle(input int wr, input int addr, input int data,
                         input int dirs, input int exe, input int op);
        int rd, t, na, nb, nr, nov;
        WR = wr[0]; ADDR = addr[2:0]; Data = data[3:0];
        DIR_SRAM = dirs[0]; DIR_EXE = exe[1:0]; OP_ALU = op[0];
        @(posedge CLK);
        rd = m_mem[addr];
        na = m_a; nb = m_b; nr = m_r; nov = m_ov;
        if (exe == 1) na = rd;
        if (exe == 2) nb = rd;
        if (exe == 3) begin
            t = op ? sgn(m_a) - sgn(m_b) : sgn(m_a) + sgn(m_b);
            nov = (t > 7 || t < -8) ? 1 : 0;
            nr = (SAT && t > 7) ? 7 : (SAT && t < -8) ? 8 : (t & 15);
        end
        if (wr) m_mem[addr] = dirs ? m_r : data;
        else m_dout = rd;
        m_a = na; m_b = nb; m_r = nr; m_ov = nov;
        @(negedge CLK);
        check_outputs("cyc");
    endtask

    task automatic wr_imm(input int addr, input int data);
        cycle(1, addr, data, 0, 0, 0);
    endtask

    task automatic alu_op(input int pa, input int pb, input int op);
        cycle(0, pa, 0, 0, 1, 0);
        cycle(0, pb, 0, 0, 2, 0);
        cycle(0, 0, 0, 0, 3, op);
    endtask

    task automatic do_reset();
        #2 RST = 1'b0;
        model_clear();
        #1 check_outputs("rst_async");
        @(negedge CLK);
        check_outputs("rst_hold");
        RST = 1'b1;
    endtask

    initial begin
        model_clear();
        repeat (2) @(negedge CLK);
        check_outputs("por");
        RST = 1'b1;
        for (int i = 0; i < 10; i++)
            cycle(1, $urandom_range(7), $urandom_range(15), 0, 0, 0);
        alu_op(1, 2, 0);
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cycle(0, i, 0, 0, 0, 0);
            check("rst_mem", int'(DOUT), 0);
        end
        cycle(0, 2, 0, 0, 0, 0);
        check("rd010", int'(DOUT), 0);
        wr_imm(2, 15);
        cycle(0, 2, 0, 0, 0, 0);
        check("wr_rd", int'(DOUT), 15);
        wr_imm(1, 3); wr_imm(3, 4);
        alu_op(1, 3, 0);
        check("add.res", int'(RES), 7);
        check("add.ov", int'(OV), 0);
        cycle(1, 5, 0, 1, 0, 0);
        cycle(0, 5, 0, 0, 0, 0);
        check("wb", int'(DOUT), 7);
        wr_imm(0, 7); wr_imm(1, 1);
        alu_op(0, 1, 0);
        check("ovadd.res", int'(RES), SAT ? 7 : 8);
        check("ovadd.ov", int'(OV), 1);
        wr_imm(2, 8);
        alu_op(2, 1, 1);
        check("ovsub.res", int'(RES), SAT ? 8 : 7);
        check("ovsub.ov", int'(OV), 1);
        wr_imm(3, 3); wr_imm(4, 5);
        alu_op(3, 4, 1);
        check("sub.res", int'(RES), 14);
        check("sub.ov", int'(OV), 0);
        wr_imm(3, 6);
        cycle(1, 3, 10, 0, 1, 0);
        cycle(0, 4, 0, 0, 2, 0);
        cycle(0, 0, 0, 0, 3, 0);
        check("haz_lda.res", int'(RES), SAT ? 7 : 11);
        cycle(0, 3, 0, 0, 0, 0);
        check("haz_lda.mem", int'(DOUT), 10);
        wr_imm(6, 0);
        cycle(0, 1, 0, 0, 1, 0);
        cycle(0, 1, 0, 0, 2, 0);
        cycle(1, 6, 0, 1, 3, 0);
        cycle(0, 6, 0, 0, 0, 0);
        check("haz_wb.old", int'(DOUT), SAT ? 7 : 11);
        check("haz_wb.new", int'(RES), 2);
        cycle(0, 1, 0, 0, 1, 0);
        cycle(0, 4, 0, 0, 2, 0);
        do_reset();
        check("mid_rst.res", int'(RES), 0);
        check("mid_rst.ov", int'(OV), 0);
        cycle(0, 0, 0, 0, 3, 0);
        check("mid_rst.run", int'(RES), 0);
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(60) == 0) do_reset();
            else cycle($urandom_range(1), $urandom_range(7), $urandom_range(15),
                       $urandom_range(1), $urandom_range(3), $urandom_range(1));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
